div_iter: RTL and testbench

//  Iterative radix-2 restoring divider for the EX-stage DIV/DIVU path; counterpart to the pipelined multiplier.

---
 rtl/div_iter.sv | 87 ++++++++
 tb/tb_div_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Results are registered on entry to DONE and held until the next completed operation.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             busy,
    output logic             complete,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dy, r_s, r_r;
    logic             r_sign_q, r_sign_r, r_yzero;
    logic             w_accept, w_last, w_ge;
    logic [WIDTH:0]   w_sh, w_trial;
    logic [WIDTH-1:0] w_rem_n, w_quo_n, w_ax, w_ay;

    assign busy     = (r_state == CALC);
    assign complete = (r_state == DONE);
    assign s        = r_s;
    assign r        = r_r;
    assign w_accept = div & ~busy & ~cancel;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_ax     = (div_signed & x[WIDTH-1]) ? -x : x;
    assign w_ay     = (div_signed & y[WIDTH-1]) ? -y : y;
    // The dividend shifts out of r_quo while quotient bits shift in behind it.
    assign w_sh     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_sh - {1'b0, r_dy};
    assign w_ge     = ~w_trial[WIDTH];
    assign w_rem_n  = w_ge ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quo_n  = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge div_clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? CALC : IDLE;
            CALC:       w_next = cancel ? IDLE : (w_last ? DONE : CALC);
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dy     <= '0;
            r_s      <= '0;
            r_r      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_yzero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_ax;
            r_dy     <= w_ay;
            r_sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            r_sign_r <= div_signed & x[WIDTH-1];
            r_yzero  <= (y == '0);
        end else if (busy && !cancel) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                // Divide by zero forces all-ones; the remainder naturally comes out as x.
                r_s <= r_yzero ? '1 : (r_sign_q ? -w_quo_n : w_quo_n);
                r_r <= r_sign_r ? -w_rem_n : w_rem_n;
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and model-checked tests for the iterative divider.
module tb_div_iter;
    logic        clk = 1'b0, reset = 1'b1, div = 1'b0, div_signed = 1'b0, cancel = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        busy, complete;
    logic [31:0] s, r;
    int          n_vec = 0, n_err = 0;

    div_iter #(.WIDTH(32)) dut (
        .div_clk(clk), .reset(reset), .div(div), .div_signed(div_signed),
        .x(x), .y(y), .cancel(cancel), .busy(busy), .complete(complete), .s(s), .r(r)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sg) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        sa = a;
        sb = b;
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    // Starts one op and waits for complete; returns with the bench parked on the DONE-cycle negedge.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        div = 1'b1; div_signed = sg; x = a; y = b;
        lat = -1;
        bcnt = 0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            div = 1'b0; div_signed = 1'($urandom); x = $urandom; y = $urandom;
            if (busy) bcnt++;
            if (complete) lat = c;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if ({busy, complete} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {busy, complete}); end
        n_vec++; if (s !== 32'd0) begin n_err++; $display("FAIL reset_s: got %h expected 0", s); end
        n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL reset_r: got %h expected 0", r); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, bcnt;
        run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL unsigned_latency: got %0d expected 33", lat); end
        n_vec++; if (bcnt !== 32) begin n_err++; $display("FAIL unsigned_busy_cycles: got %0d expected 32", bcnt); end
        n_vec++; if (s !== 32'd14) begin n_err++; $display("FAIL unsigned_s: got %h expected %h", s, 32'd14); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL unsigned_r: got %h expected %h", r, 32'd2); end
        @(negedge clk);
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL unsigned_pulse_width: got %b expected 0", complete); end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        n_vec++; if (s !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL signed_neg_x_s: got %h expected FFFFFFFD", s); end
        n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL signed_neg_x_r: got %h expected FFFFFFFF", r); end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        n_vec++; if (s !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL signed_neg_y_s: got %h expected FFFFFFFD", s); end
        n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL signed_neg_y_r: got %h expected 00000001", r); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL signed_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_corners();
        int lat, bcnt;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        n_vec++; if ({s, r} !== {32'h8000_0000, 32'd0}) begin n_err++; $display("FAIL min_div_m1: got %h/%h expected 80000000/00000000", s, r); end
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
        n_vec++; if ({s, r} !== {32'hFFFF_FFFF, 32'd0}) begin n_err++; $display("FAIL max_div_1: got %h/%h expected FFFFFFFF/00000000", s, r); end
        run_op(1'b0, 32'h1234, 32'd0, lat, bcnt);
        n_vec++; if ({s, r} !== {32'hFFFF_FFFF, 32'h1234}) begin n_err++; $display("FAIL divzero_u: got %h/%h expected FFFFFFFF/00001234", s, r); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divzero_latency: got %0d expected 33", lat); end
        run_op(1'b1, 32'h1234, 32'd0, lat, bcnt);
        n_vec++; if ({s, r} !== {32'hFFFF_FFFF, 32'h1234}) begin n_err++; $display("FAIL divzero_s: got %h/%h expected FFFFFFFF/00001234", s, r); end
        run_op(1'b1, 32'hFFFF_FFF8, 32'd0, lat, bcnt);
        n_vec++; if ({s, r} !== {32'hFFFF_FFFF, 32'hFFFF_FFF8}) begin n_err++; $display("FAIL divzero_neg: got %h/%h expected FFFFFFFF/FFFFFFF8", s, r); end
    endtask

    task automatic test_cancel();
        int lat, bcnt, ncomp;
        run_op(1'b0, 32'd1000, 32'd3, lat, bcnt);
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            div = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_vec++; if ({busy, complete} !== 2'b00) begin n_err++; $display("FAIL cancel_abort: got busy/complete %b expected 00", {busy, complete}); end
        ncomp = 0;
        repeat (40) begin @(negedge clk); if (complete) ncomp++; end
        n_vec++; if (ncomp !== 0) begin n_err++; $display("FAIL cancel_no_complete: got %0d pulses expected 0", ncomp); end
        n_vec++; if ({s, r} !== {32'd333, 32'd1}) begin n_err++; $display("FAIL cancel_hold: got %h/%h expected 0000014D/00000001", s, r); end
        div = 1'b1; cancel = 1'b1; x = 32'd50; y = 32'd5;
        @(negedge clk);
        div = 1'b0; cancel = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_beats_div: got busy %b expected 0", busy); end
        run_op(1'b0, 32'd1000, 32'd10, lat, bcnt);
        n_vec++; if ({s, r} !== {32'd100, 32'd0} || lat !== 33) begin n_err++; $display("FAIL cancel_restart: got %h/%h lat %0d expected 00000064/00000000 lat 33", s, r, lat); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_vec++; if ({s, r, complete} !== {32'd100, 32'd0, 1'b0}) begin n_err++; $display("FAIL cancel_in_done: got %h/%h c%b expected 00000064/00000000 c0", s, r, complete); end
    endtask

    task automatic test_reset_mid();
        int lat, ncomp;
        @(negedge clk);
        div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            div = (c == 5);
            x = (c == 5) ? 32'd50 : 32'd0;
            y = (c == 5) ? 32'd5 : 32'd0;
            if (complete) lat = c;
        end
        n_vec++; if ({s, r} !== {32'd14, 32'd2} || lat !== 33) begin n_err++; $display("FAIL div_while_busy: got %h/%h lat %0d expected 0000000E/00000002 lat 33", s, r, lat); end
        div = 1'b1; x = 32'd1000; y = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            div = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if ({busy, complete, s, r} !== 66'd0) begin n_err++; $display("FAIL reset_mid_calc: got b%b c%b %h/%h expected all zero", busy, complete, s, r); end
        ncomp = 0;
        repeat (40) begin @(negedge clk); if (complete) ncomp++; end
        n_vec++; if (ncomp !== 0) begin n_err++; $display("FAIL reset_no_complete: got %0d pulses expected 0", ncomp); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
        n_vec++; if ({s, r} !== {32'd14, 32'd2}) begin n_err++; $display("FAIL b2b_first: got %h/%h expected 0000000E/00000002", s, r); end
        div = 1'b1; div_signed = 1'b1; x = 32'hFFFF_FFF9; y = 32'd2;
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            div = 1'b0;
            if (c == 1 && busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
            if (complete) lat = c;
        end
        n_vec++;
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        n_vec++; if ({s, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL b2b_second: got %h/%h expected FFFFFFFD/FFFFFFFF", s, r); end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic        sg;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 250; i++) begin
            sg = 1'($urandom);
            a = $urandom;
            case (i % 5)
                0:       b = $urandom_range(15, 0);
                1:       b = -$urandom_range(8, 1);
                2:       b = a >> $urandom_range(31, 0);
                default: b = $urandom;
            endcase
            exp = ref_div(sg, a, b);
            run_op(sg, a, b, lat, bcnt);
            n_vec++;
            if ({s, r} !== exp || lat !== 33) begin
                n_err++;
                $display("FAIL random_%0d: %s %h/%h got %h/%h lat %0d expected %h/%h lat 33",
                         i, sg ? "signed" : "unsigned", a, b, s, r, lat, exp[63:32], exp[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
